// File: rtl/stack_sequencer_if.sv
// Byte-wide req/ack memory port used by the stack sequencer.
// The master holds req, we, addr and wdata stable until ack.
interface stack_sequencer_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/stack_sequencer.sv
// Two-byte stack transfer sequencer for 8080 PUSH/POP/CALL/RET.
// Strobes the stack pointer, waits for its address, runs two byte cycles.
module stack_sequencer #(
    parameter int SP_LAT = 2
) (
    input  logic                      clk50M_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [15:0]               push_data_i,
    output logic [15:0]               pop_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic [15:0]               sp_addr_i,
    output logic                      sp_inc_o,
    output logic                      sp_dec_o,
    stack_sequencer_if.master         mem
);

    typedef enum logic [3:0] {
        IDLE,
        P_DEC1,
        P_WAIT1,
        P_WR_HI,
        P_DEC2,
        P_WAIT2,
        P_WR_LO,
        Q_RD_LO,
        Q_INC1,
        Q_WAIT1,
        Q_RD_HI,
        Q_INC2,
        Q_WAIT2,
        DONE
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(SP_LAT - 1);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [15:0] pdata;
    logic        ack;
    logic        wait_done;
    logic        mem_n;
    logic        mem_entry;
    logic        wr_n;
    logic        strobe;

    assign ack       = mem.mem_req_o && mem.mem_ack_i;
    assign wait_done = (cnt == 3'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (push_i)
                    state_n = P_DEC1;
                else if (pop_i)
                    state_n = Q_RD_LO;
            end
            P_DEC1:  state_n = P_WAIT1;
            P_WAIT1: if (wait_done) state_n = P_WR_HI;
            P_WR_HI: if (ack) state_n = P_DEC2;
            P_DEC2:  state_n = P_WAIT2;
            P_WAIT2: if (wait_done) state_n = P_WR_LO;
            P_WR_LO: if (ack) state_n = DONE;
            Q_RD_LO: if (ack) state_n = Q_INC1;
            Q_INC1:  state_n = Q_WAIT1;
            Q_WAIT1: if (wait_done) state_n = Q_RD_HI;
            Q_RD_HI: if (ack) state_n = Q_INC2;
            Q_INC2:  state_n = Q_WAIT2;
            Q_WAIT2: if (wait_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_n      = (state_n == P_WR_HI) || (state_n == P_WR_LO);
        mem_n     = wr_n || (state_n == Q_RD_LO) || (state_n == Q_RD_HI);
        mem_entry = mem_n && (state_n != state);
        strobe    = (state == P_DEC1) || (state == P_DEC2) ||
                    (state == Q_INC1) || (state == Q_INC2);
    end

    always_ff @(posedge clk50M_i) begin
        if (rst_i) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            pdata           <= 16'h0000;
            pop_data_o      <= 16'h0000;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            sp_inc_o        <= 1'b0;
            sp_dec_o        <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= 16'h0000;
            mem.mem_wdata_o <= 8'h00;
        end else begin
            state    <= state_n;
            busy_o   <= (state_n != IDLE) && (state_n != DONE);
            done_o   <= (state_n == DONE);
            sp_dec_o <= (state_n == P_DEC1) || (state_n == P_DEC2);
            sp_inc_o <= (state_n == Q_INC1) || (state_n == Q_INC2);
            mem.mem_req_o <= mem_n;

            // the wait counter is armed while the strobe is out
            if (strobe)
                cnt <= LAT_M1;
            else if (cnt != 3'd0)
                cnt <= cnt - 3'd1;

            if (state == IDLE && push_i)
                pdata <= push_data_i;

            if (mem_entry) begin
                mem.mem_addr_o <= sp_addr_i;
                mem.mem_we_o   <= wr_n;
                if (state_n == P_WR_HI)
                    mem.mem_wdata_o <= pdata[15:8];
                else if (state_n == P_WR_LO)
                    mem.mem_wdata_o <= pdata[7:0];
            end

            if (ack && state == Q_RD_LO)
                pop_data_o[7:0] <= mem.mem_rdata_i;
            if (ack && state == Q_RD_HI)
                pop_data_o[15:8] <= mem.mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a stack pointer model
// and a req/ack memory responder with programmable ack delay.
module tb_stack_sequencer;

    localparam int SPL = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        push_i;
    logic        pop_i;
    logic [15:0] push_data_i;
    logic [15:0] pop_data_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sp_addr_i;
    logic        sp_inc_o;
    logic        sp_dec_o;

    stack_sequencer_if mif ();

    stack_sequencer #(.SP_LAT(SPL)) dut (
        .clk50M_i    (clk),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .push_data_i (push_data_i),
        .pop_data_o  (pop_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sp_addr_i   (sp_addr_i),
        .sp_inc_o    (sp_inc_o),
        .sp_dec_o    (sp_dec_o),
        .mem         (mif.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  rd_mem [0:65535];
    logic [15:0] sp_base = 16'h0000;
    logic [15:0] sp_off  = 16'h0000;
    int          ack_dly = 0;
    int          cnt     = 0;

    assign sp_addr_i = sp_base + sp_off;

    logic [15:0] q_addr [$];
    logic        q_we   [$];
    logic [7:0]  q_dat  [$];
    int          n_inc    = 0;
    int          n_dec    = 0;
    int          n_viol   = 0;
    int          unstable = 0;
    logic [7:0]  pi = 8'h00;
    logic [7:0]  pd = 8'h00;
    logic        prev_hold = 1'b0;
    logic        prev_inc  = 1'b0;
    logic        prev_dec  = 1'b0;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // responder: ack after ack_dly wait cycles of a held request
    always @(negedge clk) begin
        mif.mem_ack_i   = mif.mem_req_o && (cnt == ack_dly);
        mif.mem_rdata_i = rd_mem[mif.mem_addr_o];
    end

    always @(negedge clk) begin
        #2;
        if (mif.mem_req_o && mif.mem_ack_i) begin
            q_addr.push_back(mif.mem_addr_o);
            q_we.push_back(mif.mem_we_o);
            q_dat.push_back(mif.mem_we_o ? mif.mem_wdata_o
                                         : mif.mem_rdata_i);
        end
        if (prev_hold && (!mif.mem_req_o || mif.mem_addr_o != prev_addr ||
                          mif.mem_we_o != prev_we ||
                          mif.mem_wdata_o != prev_wdata))
            unstable++;
        prev_hold  = mif.mem_req_o && !mif.mem_ack_i;
        prev_addr  = mif.mem_addr_o;
        prev_we    = mif.mem_we_o;
        prev_wdata = mif.mem_wdata_o;
        if (mif.mem_req_o && !mif.mem_ack_i)
            cnt++;
        else
            cnt = 0;
        if (sp_inc_o) n_inc++;
        if (sp_dec_o) n_dec++;
        if ((sp_inc_o && sp_dec_o) || (sp_inc_o && prev_inc) ||
            (sp_dec_o && prev_dec))
            n_viol++;
        prev_inc = sp_inc_o;
        prev_dec = sp_dec_o;
        pi = {pi[6:0], sp_inc_o};
        pd = {pd[6:0], sp_dec_o};
        if (pi[SPL]) sp_off = sp_off + 16'd1;
        if (pd[SPL]) sp_off = sp_off - 16'd1;
    end

    task automatic set_sp(input logic [15:0] v);
        sp_base = v - sp_off;
    endtask

    task automatic do_op(input logic psh, input logic pp,
                         input logic [15:0] d, input int mid_pop,
                         output int lat);
        @(negedge clk);
        push_i = psh;
        pop_i = pp;
        push_data_i = d;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            push_i = 1'b0;
            pop_i = (n == mid_pop);
            if (done_o) begin
                lat = n;
                break;
            end
        end
        pop_i = 1'b0;
    endtask

    int lat;
    int b;
    int i0;
    int d0;

    initial begin
        rst_i = 1'b1;
        push_i = 1'b0;
        pop_i = 1'b0;
        push_data_i = 16'h0000;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_req", mif.mem_req_o, 0);
        check("rst_strobes", {sp_inc_o, sp_dec_o}, 0);
        check("rst_pop_data", pop_data_o, 16'h0000);
        rst_i = 1'b0;
        @(negedge clk);

        // push ABCD at SP=1000
        set_sp(16'h1000);
        b = q_addr.size(); i0 = n_inc; d0 = n_dec;
        do_op(1'b1, 1'b0, 16'hABCD, 0, lat);
        check("push_lat", lat, 9);
        check("push_ntr", q_addr.size() - b, 2);
        check("push_tr0", {q_we[b], q_addr[b], q_dat[b]}, {1'b1, 16'h0FFF, 8'hAB});
        check("push_tr1", {q_we[b+1], q_addr[b+1], q_dat[b+1]}, {1'b1, 16'h0FFE, 8'hCD});
        check("push_ndec", n_dec - d0, 2);
        check("push_ninc", n_inc - i0, 0);
        check("push_sp", sp_addr_i, 16'h0FFE);
        check("push_busy_done", busy_o, 0);

        // pop at SP=0FFE, issued in the cycle after done
        rd_mem[16'h0FFE] = 8'h34;
        rd_mem[16'h0FFF] = 8'h12;
        b = q_addr.size(); i0 = n_inc; d0 = n_dec;
        do_op(1'b0, 1'b1, 16'h0000, 0, lat);
        check("pop_lat", lat, 9);
        check("pop_data", pop_data_o, 16'h1234);
        check("pop_ntr", q_addr.size() - b, 2);
        check("pop_tr0", {q_we[b], q_addr[b]}, {1'b0, 16'h0FFE});
        check("pop_tr1", {q_we[b+1], q_addr[b+1]}, {1'b0, 16'h0FFF});
        check("pop_ninc", n_inc - i0, 2);
        check("pop_ndec", n_dec - d0, 0);
        check("pop_sp", sp_addr_i, 16'h1000);

        // wraparound push and pop
        set_sp(16'h0000);
        b = q_addr.size();
        do_op(1'b1, 1'b0, 16'h5AA5, 0, lat);
        check("wpush_tr0", {q_addr[b], q_dat[b]}, {16'hFFFF, 8'h5A});
        check("wpush_tr1", {q_addr[b+1], q_dat[b+1]}, {16'hFFFE, 8'hA5});
        rd_mem[16'hFFFF] = 8'h77;
        rd_mem[16'h0000] = 8'h88;
        set_sp(16'hFFFF);
        b = q_addr.size();
        do_op(1'b0, 1'b1, 16'h0000, 0, lat);
        check("wpop_tr0", q_addr[b], 16'hFFFF);
        check("wpop_tr1", q_addr[b+1], 16'h0000);
        check("wpop_data", pop_data_o, 16'h8877);
        check("wpop_sp", sp_addr_i, 16'h0001);

        // ack delayed by 3 cycles on each memory cycle
        ack_dly = 3;
        set_sp(16'h3000);
        b = q_addr.size();
        do_op(1'b1, 1'b0, 16'h1122, 0, lat);
        check("slow_push_lat", lat, 15);
        check("slow_push_tr1", {q_addr[b+1], q_dat[b+1]}, {16'h2FFE, 8'h22});
        rd_mem[16'h2FFE] = 8'h22;
        rd_mem[16'h2FFF] = 8'h11;
        do_op(1'b0, 1'b1, 16'h0000, 0, lat);
        check("slow_pop_lat", lat, 15);
        check("slow_pop_data", pop_data_o, 16'h1122);
        check("stable", unstable, 0);
        ack_dly = 0;

        // simultaneous request plus a pop pulsed mid-push
        set_sp(16'h2000);
        b = q_addr.size(); i0 = n_inc; d0 = n_dec;
        do_op(1'b1, 1'b1, 16'hBEEF, 4, lat);
        repeat (4) @(negedge clk);
        check("both_lat", lat, 9);
        check("both_ntr", q_addr.size() - b, 2);
        check("both_we", {q_we[b], q_we[b+1]}, 2'b11);
        check("both_ninc", n_inc - i0, 0);
        check("both_ndec", n_dec - d0, 2);
        check("both_busy", busy_o, 0);

        // reset asserted during P_WAIT2
        set_sp(16'h4000);
        @(negedge clk);
        push_i = 1'b1;
        push_data_i = 16'hC3C3;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            push_i = 1'b0;
            if (n == 6) rst_i = 1'b1;
        end
        check("mrst_busy", busy_o, 0);
        check("mrst_req", mif.mem_req_o, 0);
        check("mrst_strobes", {sp_inc_o, sp_dec_o}, 0);
        check("mrst_done", done_o, 0);
        check("mrst_pop_data", pop_data_o, 16'h0000);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rd_mem[16'h5000] = 8'h9C;
        rd_mem[16'h5001] = 8'hE7;
        set_sp(16'h5000);
        b = q_addr.size();
        do_op(1'b0, 1'b1, 16'h0000, 0, lat);
        check("mrst_pop_lat", lat, 9);
        check("mrst_pop_data2", pop_data_o, 16'hE79C);
        check("mrst_pop_tr0", q_addr[b], 16'h5000);
        check("strobe_rules", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
